// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: turns SPI command frames into RAM accesses and shares the
// single-port RAM with a host port through a two-way round-robin arbiter.
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [9:0]            spi_rx_data_i,
  input  logic                  spi_rx_valid_i,
  output logic [DATA_WIDTH-1:0] spi_tx_data_o,
  output logic                  spi_tx_valid_o,
  output logic                  spi_ovf_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  host_rvalid_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
  typedef struct packed {
    logic                  v;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } pend_t;
  state_t                state_q, state_d;
  pend_t                 pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q, tx_data_q, host_rdata_q;
  logic                  ovf_q, ovf_d, last_host_q, resp_host_q, ram_en_q, ram_we_q;
  logic                  host_gnt_q, tx_valid_q, host_rvalid_q;
  logic                  spi_win, host_win;
  logic [1:0]            cmd;
  function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    cmd      = spi_rx_data_i[9:8];
    spi_win  = (state_q == IDLE) && pend_q.v && (!host_req_i || last_host_q);
    host_win = (state_q == IDLE) && host_req_i && !spi_win;
    state_d  = (state_q == IDLE) ? ((spi_win || host_win) ? ACCESS : IDLE)
             : (state_q == ACCESS && !ram_we_q) ? CAPTURE : IDLE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    if (spi_win) pend_d.v = 1'b0;
    // a command landing on the grant cycle refills the buffer the grant just freed
    if (spi_rx_valid_i) begin
      wr_ptr_d = (cmd == 2'b00) ? spi_rx_data_i[ADDR_WIDTH-1:0] : (cmd == 2'b01) ? inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = (cmd == 2'b10) ? spi_rx_data_i[ADDR_WIDTH-1:0] : (cmd == 2'b11) ? inc(rd_ptr_q) : rd_ptr_q;
      if (cmd[0] && pend_q.v && !spi_win) ovf_d = 1'b1;
      else if (cmd[0]) pend_d = {1'b1, !cmd[1], cmd[1] ? rd_ptr_q : wr_ptr_q, spi_rx_data_i[DATA_WIDTH-1:0]};
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ovf_q         <= 1'b0;
      last_host_q   <= 1'b1;
      resp_host_q   <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_gnt_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ovf_q         <= ovf_d;
      ram_en_q      <= spi_win || host_win;
      host_gnt_q    <= host_win;
      tx_valid_q    <= (state_q == CAPTURE) && !resp_host_q;
      host_rvalid_q <= (state_q == CAPTURE) && resp_host_q;
      if (spi_win || host_win) begin
        last_host_q <= host_win;
        resp_host_q <= host_win;
        ram_we_q    <= spi_win ? pend_q.we : host_we_i;
        ram_addr_q  <= spi_win ? pend_q.addr : host_addr_i;
        ram_wdata_q <= spi_win ? pend_q.data : host_wdata_i;
      end
      if (state_q == CAPTURE && resp_host_q) host_rdata_q <= ram_rdata_i;
      if (state_q == CAPTURE && !resp_host_q) tx_data_q <= ram_rdata_i;
    end
  end
  assign spi_tx_data_o  = tx_data_q;
  assign spi_tx_valid_o = tx_valid_q;
  assign spi_ovf_o      = ovf_q;
  assign host_gnt_o     = host_gnt_q;
  assign host_rdata_o   = host_rdata_q;
  assign host_rvalid_o  = host_rvalid_q;
  assign ram_en_o       = ram_en_q;
  assign ram_we_o       = ram_we_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_wdata_o    = ram_wdata_q;
endmodule
